// File: rtl/gry_pkg.sv
// Gray-code helpers shared by the pointer counter and FIFO pointer compare logic.
// Functions work on 32-bit values; callers zero-extend narrower operands and
// truncate the result. Zero-extension is harmless for both directions because
// the extra upper bits stay zero.
package gry_pkg;

  localparam int GRY_MAX_W = 32;

  function automatic logic [GRY_MAX_W-1:0] bin_to_gry(input logic [GRY_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [GRY_MAX_W-1:0] gry_to_bin(input logic [GRY_MAX_W-1:0] g);
    logic [GRY_MAX_W-1:0] b;
    b = g;
    for (int i = 1; i < GRY_MAX_W; i++) b = b ^ (g >> i);
    return b;
  endfunction

endpackage

// File: rtl/gry_ptr_ctr_if.sv
// Control/status bundle of the Gray pointer counter.
//   en, dir, clr, ld, ld_gry          : step / clear / load controls (master -> slave)
//   bin_cnt_comb                      : next binary count, combinational
//   bin_cnt_reg, gry_cnt_reg, wrap    : registered count and wrap pulse
interface gry_ptr_ctr_if #(parameter int P_NUM_BITS = 8);
  logic                  en;
  logic                  dir;
  logic                  clr;
  logic                  ld;
  logic [P_NUM_BITS-1:0] ld_gry;
  logic [P_NUM_BITS-1:0] bin_cnt_comb;
  logic [P_NUM_BITS-1:0] bin_cnt_reg;
  logic [P_NUM_BITS-1:0] gry_cnt_reg;
  logic                  wrap;

  modport master (
    output en, dir, clr, ld, ld_gry,
    input  bin_cnt_comb, bin_cnt_reg, gry_cnt_reg, wrap
  );

  modport slave (
    input  en, dir, clr, ld, ld_gry,
    output bin_cnt_comb, bin_cnt_reg, gry_cnt_reg, wrap
  );
endinterface

// File: rtl/gry2bin.sv
// Gray-to-binary converter for the load path.
//   gry_i : Gray-coded input
//   bin_o : binary equivalent
// Each output bit is a reduction XOR of the Gray bits from the MSB down to it,
// so no output bit depends on another (no ripple through bin_o).
module gry2bin #(
  parameter int P_NUM_BITS = 8
) (
  input  logic [P_NUM_BITS-1:0] gry_i,
  output logic [P_NUM_BITS-1:0] bin_o
);
  for (genvar i = 0; i < P_NUM_BITS; i++) begin : g_bit
    assign bin_o[i] = ^gry_i[P_NUM_BITS-1:i];
  end
endmodule

// File: rtl/gry_ptr_ctr.sv
// Up/down binary counter with registered Gray output, for FIFO pointers.
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : slave side of gry_ptr_ctr_if (en/dir/clr/ld/ld_gry in,
//          bin_cnt_comb/bin_cnt_reg/gry_cnt_reg/wrap out)
// Next value priority: clr > ld > en > hold. wrap pulses only for en steps
// crossing the all-ones/zero boundary, never for clr or ld.
module gry_ptr_ctr
  import gry_pkg::*;
#(
  parameter int P_NUM_BITS = 8,
  parameter int P_RST_VAL  = 0
) (
  input  logic          clk,
  input  logic          rst,
  gry_ptr_ctr_if.slave  bus
);
  localparam logic [P_NUM_BITS-1:0] RST_BIN = P_NUM_BITS'(P_RST_VAL);
  localparam logic [P_NUM_BITS-1:0] RST_GRY = P_NUM_BITS'(bin_to_gry(32'(P_RST_VAL)));
  localparam logic [P_NUM_BITS-1:0] ONE     = P_NUM_BITS'(1);
  localparam logic [P_NUM_BITS-1:0] ALL1    = '1;

  logic [P_NUM_BITS-1:0] ld_bin;
  logic [P_NUM_BITS-1:0] bin_d, bin_q;
  logic [P_NUM_BITS-1:0] gry_d, gry_q;
  logic                  wrap_d, wrap_q;

  gry2bin #(.P_NUM_BITS(P_NUM_BITS)) u_gry2bin (
    .gry_i (bus.ld_gry),
    .bin_o (ld_bin)
  );

  always_comb begin
    bin_d  = bin_q;
    wrap_d = 1'b0;
    if (bus.clr) begin
      bin_d = RST_BIN;
    end else if (bus.ld) begin
      bin_d = ld_bin;
    end else if (bus.en) begin
      if (bus.dir) begin
        bin_d  = bin_q - ONE;
        wrap_d = (bin_q == '0);
      end else begin
        bin_d  = bin_q + ONE;
        wrap_d = (bin_q == ALL1);
      end
    end
  end

  // Gray is derived from the next binary value so both registers stay coherent.
  assign gry_d = P_NUM_BITS'(bin_to_gry(32'(bin_d)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_q  <= RST_BIN;
      gry_q  <= RST_GRY;
      wrap_q <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      gry_q  <= gry_d;
      wrap_q <= wrap_d;
    end
  end

  assign bus.bin_cnt_comb = bin_d;
  assign bus.bin_cnt_reg  = bin_q;
  assign bus.gry_cnt_reg  = gry_q;
  assign bus.wrap         = wrap_q;
endmodule

// File: tb/tb_gry_ptr_ctr.sv
module tb_gry_ptr_ctr;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  localparam int R8 = 37;

  gry_ptr_ctr_if #(.P_NUM_BITS(4)) if4  ();
  gry_ptr_ctr_if #(.P_NUM_BITS(4)) if4r ();
  gry_ptr_ctr_if #(.P_NUM_BITS(8)) if8  ();

  gry_ptr_ctr #(.P_NUM_BITS(4), .P_RST_VAL(0))  u_d4  (.clk(clk), .rst(rst), .bus(if4));
  gry_ptr_ctr #(.P_NUM_BITS(4), .P_RST_VAL(3))  u_d4r (.clk(clk), .rst(rst), .bus(if4r));
  gry_ptr_ctr #(.P_NUM_BITS(8), .P_RST_VAL(R8)) u_d8  (.clk(clk), .rst(rst), .bus(if8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Inverse Gray by exhaustive search over the code space.
  function automatic int gray_inv(input int g, input int n);
    for (int b = 0; b < (1 << n); b++)
      if ((b ^ (b >> 1)) == g) return b;
    return -1;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    checks++;
    if (if4.bin_cnt_reg !== 4'd0 || if4.gry_cnt_reg !== 4'd0 || if4.wrap !== 1'b0) begin
      errors++; $display("FAIL reset_d4 bin=%0d gry=%b wrap=%b want 0 0000 0",
                         if4.bin_cnt_reg, if4.gry_cnt_reg, if4.wrap);
    end
    checks++;
    if (if4r.bin_cnt_reg !== 4'd3 || if4r.gry_cnt_reg !== 4'b0010 || if4r.wrap !== 1'b0) begin
      errors++; $display("FAIL reset_d4r bin=%0d gry=%b wrap=%b want 3 0010 0",
                         if4r.bin_cnt_reg, if4r.gry_cnt_reg, if4r.wrap);
    end
    checks++;
    if (if8.bin_cnt_reg !== 8'd37 || if8.gry_cnt_reg !== 8'd55 || if8.wrap !== 1'b0) begin
      errors++; $display("FAIL reset_d8 bin=%0d gry=%0d wrap=%b want 37 55 0",
                         if8.bin_cnt_reg, if8.gry_cnt_reg, if8.wrap);
    end
    rst = 1'b0;
    if4.en = 1'b1; if4.dir = 1'b0;
    repeat (5) tick();
    checks++;
    if (if4.bin_cnt_reg !== 4'd5 || if4.gry_cnt_reg !== 4'b0111) begin
      errors++; $display("FAIL count_to_5 bin=%0d gry=%b want 5 0111",
                         if4.bin_cnt_reg, if4.gry_cnt_reg);
    end
    // Asynchronous reset mid-count, observed before the next clock edge.
    #3 rst = 1'b1;
    #1;
    checks++;
    if (if4.bin_cnt_reg !== 4'd0 || if4.gry_cnt_reg !== 4'd0 || if4.wrap !== 1'b0) begin
      errors++; $display("FAIL async_reset bin=%0d gry=%b wrap=%b want 0 0000 0",
                         if4.bin_cnt_reg, if4.gry_cnt_reg, if4.wrap);
    end
    tick();
    checks++;
    if (if4.bin_cnt_reg !== 4'd0) begin
      errors++; $display("FAIL reset_hold bin=%0d want 0", if4.bin_cnt_reg);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (if4.bin_cnt_reg !== 4'd1 || if4.gry_cnt_reg !== 4'b0001) begin
      errors++; $display("FAIL resume bin=%0d gry=%b want 1 0001",
                         if4.bin_cnt_reg, if4.gry_cnt_reg);
    end
    if4.en = 1'b0;
  endtask

  task automatic test_up_wrap();
    logic [3:0] eb [3];
    logic       ew [3];
    eb = '{4'd15, 4'd0, 4'd1};
    ew = '{1'b0, 1'b1, 1'b0};
    if4.ld = 1'b1; if4.ld_gry = 4'b1001;
    tick();
    if4.ld = 1'b0;
    checks++;
    if (if4.bin_cnt_reg !== 4'd14 || if4.wrap !== 1'b0) begin
      errors++; $display("FAIL up_preload bin=%0d wrap=%b want 14 0", if4.bin_cnt_reg, if4.wrap);
    end
    if4.en = 1'b1; if4.dir = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (if4.bin_cnt_reg !== eb[i] || if4.gry_cnt_reg !== (eb[i] ^ (eb[i] >> 1)) ||
          if4.wrap !== ew[i]) begin
        errors++; $display("FAIL up_wrap step%0d bin=%0d gry=%b wrap=%b want %0d %b %b", i,
                           if4.bin_cnt_reg, if4.gry_cnt_reg, if4.wrap,
                           eb[i], eb[i] ^ (eb[i] >> 1), ew[i]);
      end
    end
    if4.en = 1'b0;
  endtask

  task automatic test_down_wrap();
    logic [3:0] eb [3];
    logic       ew [3];
    logic [3:0] prev;
    eb = '{4'd0, 4'd15, 4'd14};
    ew = '{1'b0, 1'b1, 1'b0};
    if4.ld = 1'b1; if4.ld_gry = 4'b0001;
    tick();
    if4.ld = 1'b0;
    checks++;
    if (if4.bin_cnt_reg !== 4'd1) begin
      errors++; $display("FAIL down_preload bin=%0d want 1", if4.bin_cnt_reg);
    end
    prev = if4.gry_cnt_reg;
    if4.en = 1'b1; if4.dir = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (if4.bin_cnt_reg !== eb[i] || if4.gry_cnt_reg !== (eb[i] ^ (eb[i] >> 1)) ||
          if4.wrap !== ew[i]) begin
        errors++; $display("FAIL down_wrap step%0d bin=%0d gry=%b wrap=%b want %0d %b %b", i,
                           if4.bin_cnt_reg, if4.gry_cnt_reg, if4.wrap,
                           eb[i], eb[i] ^ (eb[i] >> 1), ew[i]);
      end
      checks++;
      if ($countones(prev ^ if4.gry_cnt_reg) != 1) begin
        errors++; $display("FAIL down_onebit step%0d flips=%0d want 1", i,
                           $countones(prev ^ if4.gry_cnt_reg));
      end
      prev = if4.gry_cnt_reg;
    end
    if4.en = 1'b0;
  endtask

  task automatic test_load();
    if4.ld = 1'b1; if4.ld_gry = 4'b1110; if4.en = 1'b1; if4.dir = 1'b1;
    #1;
    checks++;
    if (if4.bin_cnt_comb !== 4'b1011) begin
      errors++; $display("FAIL load_comb got=%b want 1011", if4.bin_cnt_comb);
    end
    tick();
    checks++;
    if (if4.bin_cnt_reg !== 4'd11 || if4.gry_cnt_reg !== 4'b1110 || if4.wrap !== 1'b0) begin
      errors++; $display("FAIL load_reg bin=%0d gry=%b wrap=%b want 11 1110 0",
                         if4.bin_cnt_reg, if4.gry_cnt_reg, if4.wrap);
    end
    // Load 15 then 0 while en/up is asserted: crossing via ld must not wrap.
    if4.ld_gry = 4'b1000;
    tick();
    if4.ld_gry = 4'b0000; if4.dir = 1'b0;
    tick();
    checks++;
    if (if4.bin_cnt_reg !== 4'd0 || if4.wrap !== 1'b0) begin
      errors++; $display("FAIL load_no_wrap bin=%0d wrap=%b want 0 0", if4.bin_cnt_reg, if4.wrap);
    end
    // Clear at zero with a down step pending: clr wins, no wrap.
    if4.ld = 1'b0; if4.clr = 1'b1; if4.dir = 1'b1;
    tick();
    checks++;
    if (if4.bin_cnt_reg !== 4'd0 || if4.wrap !== 1'b0) begin
      errors++; $display("FAIL clr_no_wrap bin=%0d wrap=%b want 0 0", if4.bin_cnt_reg, if4.wrap);
    end
    if4.clr = 1'b0; if4.en = 1'b0; if4.dir = 1'b0;
  endtask

  task automatic test_priority();
    if4r.ld = 1'b1; if4r.ld_gry = 4'b1111;
    tick();
    checks++;
    if (if4r.bin_cnt_reg !== 4'd10) begin
      errors++; $display("FAIL prio_preload bin=%0d want 10", if4r.bin_cnt_reg);
    end
    if4r.clr = 1'b1; if4r.en = 1'b1;
    #1;
    checks++;
    if (if4r.bin_cnt_comb !== 4'd3) begin
      errors++; $display("FAIL prio_comb got=%0d want 3", if4r.bin_cnt_comb);
    end
    tick();
    checks++;
    if (if4r.bin_cnt_reg !== 4'd3 || if4r.gry_cnt_reg !== 4'b0010 || if4r.wrap !== 1'b0) begin
      errors++; $display("FAIL prio_reg bin=%0d gry=%b wrap=%b want 3 0010 0",
                         if4r.bin_cnt_reg, if4r.gry_cnt_reg, if4r.wrap);
    end
    if4r.clr = 1'b0; if4r.ld = 1'b0; if4r.en = 1'b0;
  endtask

  task automatic test_random();
    int   m, nm;
    logic ew;
    bit   step_only;
    logic [7:0] prev;
    if8.clr = 1'b1;
    tick();
    if8.clr = 1'b0;
    m = R8;
    prev = if8.gry_cnt_reg;
    for (int cyc = 0; cyc < 1000; cyc++) begin
      if8.clr    = ($urandom_range(0, 31) == 0);
      if8.ld     = ($urandom_range(0, 15) == 0);
      if8.en     = ($urandom_range(0, 3) != 0);
      if8.dir    = ($urandom_range(0, 1) == 1);
      if8.ld_gry = 8'($urandom_range(0, 255));
      ew = 1'b0;
      step_only = 1'b0;
      if (if8.clr)     nm = R8;
      else if (if8.ld) nm = gray_inv(int'(if8.ld_gry), 8);
      else if (if8.en) begin
        step_only = 1'b1;
        if (if8.dir) begin nm = (m + 255) % 256; ew = (m == 0);   end
        else         begin nm = (m + 1) % 256;   ew = (m == 255); end
      end else nm = m;
      #1;
      checks++;
      if (if8.bin_cnt_comb !== 8'(nm)) begin
        errors++; $display("FAIL rnd_comb cyc%0d got=%0d want %0d", cyc, if8.bin_cnt_comb, nm);
      end
      tick();
      m = nm;
      checks++;
      if (if8.bin_cnt_reg !== 8'(m) || if8.gry_cnt_reg !== 8'(m ^ (m >> 1)) || if8.wrap !== ew) begin
        errors++; $display("FAIL rnd_reg cyc%0d bin=%0d gry=%0d wrap=%b want %0d %0d %b", cyc,
                           if8.bin_cnt_reg, if8.gry_cnt_reg, if8.wrap, m, m ^ (m >> 1), ew);
      end
      if (step_only) begin
        checks++;
        if ($countones(prev ^ if8.gry_cnt_reg) != 1) begin
          errors++; $display("FAIL rnd_onebit cyc%0d flips=%0d want 1", cyc,
                             $countones(prev ^ if8.gry_cnt_reg));
        end
      end
      prev = if8.gry_cnt_reg;
    end
    if8.clr = 1'b0; if8.ld = 1'b0; if8.en = 1'b0; if8.dir = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    if4.en  = 1'b0; if4.dir  = 1'b0; if4.clr  = 1'b0; if4.ld  = 1'b0; if4.ld_gry  = '0;
    if4r.en = 1'b0; if4r.dir = 1'b0; if4r.clr = 1'b0; if4r.ld = 1'b0; if4r.ld_gry = '0;
    if8.en  = 1'b0; if8.dir  = 1'b0; if8.clr  = 1'b0; if8.ld  = 1'b0; if8.ld_gry  = '0;
    test_reset();
    test_up_wrap();
    test_down_wrap();
    test_load();
    test_priority();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
